// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus and the IF/ID record handed to decode.
typedef struct packed {
    logic [31:0] instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
} ifid_t;

interface if_stage_if #(
    parameter int XLEN = 32
) ();
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// RISC-V instruction-fetch stage: owns the fetch PC, keeps a small in-order fetch
// queue of outstanding/returned instructions and hands them to decode.
module if_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    if_stage_if.master      imem,
    output ifid_t           outputs,
    output logic            validD
);

    localparam int          PW      = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int          CW      = $clog2(FQ_DEPTH + 1) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [XLEN-1:0]     fetch_pc;
    logic [XLEN-1:0]     q_pc    [FQ_DEPTH];
    logic [31:0]         q_instr [FQ_DEPTH];
    logic [FQ_DEPTH-1:0] q_filled;
    logic [PW-1:0]       head;
    logic [PW-1:0]       tail;
    logic [PW-1:0]       fill;
    logic [CW-1:0]       used;
    logic [CW-1:0]       pending;
    logic [CW-1:0]       discard;

    logic          pop;
    logic          req;
    logic          accept;
    logic          rsp_drop;
    logic          rsp_fill;
    logic          rsp_orphan;
    logic [CW-1:0] redirect_discard;

    assign validD = q_filled[head];
    assign pop    = validD & ~StallD;

    // Responses still owed for squashed requests occupy credit too, so the
    // number of requests in flight never exceeds FQ_DEPTH across redirects.
    assign req    = ~reset & ~PCSrcE & ((used + discard) < (DEPTH_C + CW'(pop)));
    assign accept = req & imem.imem_ready;

    assign imem.imem_req  = req;
    assign imem.imem_addr = fetch_pc;

    assign rsp_drop   = imem.imem_rvalid & (discard != '0);
    assign rsp_fill   = imem.imem_rvalid & (discard == '0) & (pending != '0) & ~PCSrcE;
    assign rsp_orphan = imem.imem_rvalid & (discard == '0) & (pending == '0);

    // A response landing in the redirect cycle is dropped, so it retires one
    // credit from either the old discard count or the squashed unfilled entries.
    assign redirect_discard = discard + pending - CW'(imem.imem_rvalid & ~rsp_orphan);

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            fill     <= '0;
            used     <= '0;
            pending  <= '0;
            discard  <= '0;
            q_filled <= '0;
        end else if (PCSrcE) begin
            fetch_pc <= PCTargetE & ~XLEN'(3);
            head     <= '0;
            tail     <= '0;
            fill     <= '0;
            used     <= '0;
            pending  <= '0;
            q_filled <= '0;
            discard  <= redirect_discard;
        end else begin
            if (accept) begin
                tail     <= tail + 1'b1;
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (rsp_fill) begin
                q_filled[fill] <= 1'b1;
                fill           <= fill + 1'b1;
            end
            if (pop) begin
                q_filled[head] <= 1'b0;
                head           <= head + 1'b1;
            end
            if (rsp_drop) begin
                discard <= discard - 1'b1;
            end
            used    <= used + CW'(accept) - CW'(pop);
            pending <= pending + CW'(accept) - CW'(rsp_fill);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            q_pc[tail] <= fetch_pc;
        end
        if (rsp_fill) begin
            q_instr[fill] <= imem.imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!rsp_orphan)
                else $error("if_stage: imem response with no outstanding request");
        end
    end

    always_comb begin
        outputs.instr   = NOP;
        outputs.PC      = '0;
        outputs.PCPlus4 = '0;
        if (validD) begin
            outputs.instr   = q_instr[head];
            outputs.PC      = q_pc[head];
            outputs.PCPlus4 = q_pc[head] + XLEN'(4);
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage against a queue-level fetch model, plus directed
// scenarios with hand-computed expectations.
module tb_if_stage;
    localparam int          XLEN     = 32;
    localparam int          FQ_DEPTH = 2;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    ifid_t       outputs;
    logic        validD;

    if_stage_if #(.XLEN(XLEN)) imem ();

    if_stage #(
        .XLEN(XLEN),
        .RESET_PC(RESET_PC),
        .FQ_DEPTH(FQ_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .StallD(StallD),
        .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE),
        .imem(imem),
        .outputs(outputs),
        .validD(validD)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        filled;
    } ent_t;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    ent_t        mq[$];
    mreq_t       mem[$];
    logic [31:0] m_pc;
    int          m_discard;
    bit          m_init;
    int          cyc;
    int          last_due;
    int          lat_lo;
    int          lat_hi;
    logic        rdy_in;
    int          checks;
    int          errors;

    logic        obs_req;
    logic [31:0] obs_addr;
    logic        obs_valid;
    logic [31:0] obs_instr;
    logic [31:0] obs_pc;
    logic [31:0] obs_pc4;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive the memory side, compare against the model, then advance.
    task automatic step();
        logic        exp_valid;
        logic        exp_req;
        logic        rv;
        logic [31:0] rd;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        logic [31:0] exp_pc4;
        bit          popm;
        int          unf;
        int          lat;
        int          due;
        ent_t        e;
        if (reset) begin
            mem.delete();
            last_due = 0;
        end
        imem.imem_ready = rdy_in;
        if (!reset && mem.size() > 0 && mem[0].due <= cyc) begin
            imem.imem_rvalid = 1'b1;
            imem.imem_rdata  = tag(mem[0].addr);
            void'(mem.pop_front());
        end else begin
            imem.imem_rvalid = 1'b0;
            imem.imem_rdata  = $urandom;
        end
        #2;
        rv        = imem.imem_rvalid;
        rd        = imem.imem_rdata;
        exp_valid = (mq.size() > 0) && mq[0].filled;
        exp_instr = exp_valid ? mq[0].instr : NOP;
        exp_pc    = exp_valid ? mq[0].pc : 32'h0;
        exp_pc4   = exp_valid ? mq[0].pc + 32'd4 : 32'h0;
        popm      = exp_valid && !StallD;
        exp_req   = !reset && !PCSrcE && ((mq.size() + m_discard - int'(popm)) < FQ_DEPTH);
        obs_req   = imem.imem_req;
        obs_addr  = imem.imem_addr;
        obs_valid = validD;
        obs_instr = outputs.instr;
        obs_pc    = outputs.PC;
        obs_pc4   = outputs.PCPlus4;
        if (m_init) begin
            chk("imem_req", {31'b0, obs_req}, {31'b0, exp_req});
            chk("imem_addr", obs_addr, m_pc);
            chk("validD", {31'b0, obs_valid}, {31'b0, exp_valid});
            chk("instr", obs_instr, exp_instr);
            chk("PC", obs_pc, exp_pc);
            chk("PCPlus4", obs_pc4, exp_pc4);
        end
        @(posedge clk);
        if (reset) begin
            m_pc      = RESET_PC;
            mq.delete();
            m_discard = 0;
            m_init    = 1'b1;
        end else if (PCSrcE) begin
            unf = 0;
            foreach (mq[i]) if (!mq[i].filled) unf++;
            m_discard = m_discard + unf;
            if (rv && m_discard > 0) m_discard--;
            mq.delete();
            m_pc = PCTargetE & 32'hFFFF_FFFC;
        end else begin
            if (rv) begin
                if (m_discard > 0) begin
                    m_discard--;
                end else begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (!mq[i].filled) begin
                            e        = mq[i];
                            e.instr  = rd;
                            e.filled = 1'b1;
                            mq[i]    = e;
                            break;
                        end
                    end
                end
            end
            if (popm) void'(mq.pop_front());
            if (exp_req && rdy_in) begin
                mq.push_back('{m_pc, 32'h0, 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
        if (!reset && obs_req === 1'b1 && rdy_in) begin
            lat = $urandom_range(lat_hi, lat_lo);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            mem.push_back('{obs_addr, due});
            last_due = due;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int lat);
        reset  = 1'b1;
        StallD = 1'b0;
        PCSrcE = 1'b0;
        rdy_in = 1'b1;
        lat_lo = lat;
        lat_hi = lat;
        step();
        step();
        chk("reset validD", {31'b0, obs_valid}, 32'd0);
        chk("reset instr", obs_instr, NOP);
        chk("reset req", {31'b0, obs_req}, 32'd0);
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (obs_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk(name, {31'b0, obs_valid}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        checks = 0; errors = 0; cyc = 0; last_due = 0;
        m_init = 1'b0; m_discard = 0; m_pc = RESET_PC;
        reset = 1'b1; StallD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        rdy_in = 1'b1; lat_lo = 1; lat_hi = 1;
        imem.imem_ready = 1'b1; imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
        @(negedge clk);

        // Streaming with 1-cycle memory, then a 4-cycle decode stall.
        do_reset(1);
        step(); chk("A addr0", obs_addr, 32'h0); chk("A valid c0", {31'b0, obs_valid}, 32'd0);
        step(); chk("A addr1", obs_addr, 32'h4); chk("A valid c1", {31'b0, obs_valid}, 32'd0);
        step(); chk("A addr2", obs_addr, 32'h8); chk("A valid c2", {31'b0, obs_valid}, 32'd1);
        chk("A pc0", obs_pc, 32'h0); chk("A pc4_0", obs_pc4, 32'h4); chk("A instr0", obs_instr, 32'hCAFE_0000);
        step(); chk("A pc1", obs_pc, 32'h4); chk("A instr1", obs_instr, 32'hCAFE_0004);
        step(); chk("A pc2", obs_pc, 32'h8); chk("A pc4_2", obs_pc4, 32'hC);
        StallD = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("B pc hold", obs_pc, 32'hC);
            chk("B req full", {31'b0, obs_req}, 32'd0);
            chk("B addr hold", obs_addr, 32'h14);
        end
        StallD = 1'b0;
        step(); chk("B pc after", obs_pc, 32'hC);
        step(); chk("B pc next", obs_pc, 32'h10);
        step(); chk("B pc next2", obs_pc, 32'h14);

        // Memory not ready for 5 cycles.
        do_reset(1);
        for (int k = 0; k < 4; k++) step();
        rdy_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("D req held", {31'b0, obs_req}, 32'd1);
            chk("D addr held", obs_addr, 32'h10);
            if (k == 2) chk("D drained", {31'b0, obs_valid}, 32'd0);
        end
        rdy_in = 1'b1;
        step(); chk("D resume addr", obs_addr, 32'h10);
        step();
        step(); chk("D resume pc", obs_pc, 32'h10);

        // 3-cycle memory, two stale requests squashed by a redirect.
        do_reset(3);
        for (int k = 0; k < 5; k++) step();
        step(); chk("C addr c5", obs_addr, 32'hC);
        PCSrcE = 1'b1; PCTargetE = 32'h103;
        step(); chk("C redirect req", {31'b0, obs_req}, 32'd0);
        PCSrcE = 1'b0;
        step(); chk("C target addr", obs_addr, 32'h100); chk("C valid after", {31'b0, obs_valid}, 32'd0);
        wait_valid("C target valid timeout", 20);
        chk("C target pc", obs_pc, 32'h100); chk("C target instr", obs_instr, 32'hCAFE_0100);

        // Redirect and stall together with a response in the same cycle.
        do_reset(1);
        for (int k = 0; k < 4; k++) step();
        StallD = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h201;
        step(); chk("E redirect req", {31'b0, obs_req}, 32'd0);
        StallD = 1'b0; PCSrcE = 1'b0;
        step(); chk("E valid cleared", {31'b0, obs_valid}, 32'd0); chk("E addr", obs_addr, 32'h200);
        chk("E req", {31'b0, obs_req}, 32'd1);
        step();
        step(); chk("E valid", {31'b0, obs_valid}, 32'd1); chk("E pc", obs_pc, 32'h200);
        chk("E instr", obs_instr, 32'hCAFE_0200);

        // Reset mid-stream.
        do_reset(3);
        for (int k = 0; k < 5; k++) step();
        reset = 1'b1;
        step(); chk("F pre-reset valid", {31'b0, obs_valid}, 32'd1); chk("F reset req", {31'b0, obs_req}, 32'd0);
        reset = 1'b0;
        step(); chk("F valid", {31'b0, obs_valid}, 32'd0); chk("F nop", obs_instr, NOP);
        chk("F addr", obs_addr, RESET_PC); chk("F req", {31'b0, obs_req}, 32'd1);
        wait_valid("F refetch timeout", 20);
        chk("F pc", obs_pc, 32'h0); chk("F instr", obs_instr, 32'hCAFE_0000);

        // Randomized traffic.
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 3000; i++) begin
            reset  = ($urandom_range(999, 0) < 4);
            StallD = ($urandom_range(99, 0) < 30);
            PCSrcE = ($urandom_range(99, 0) < 5);
            rdy_in = ($urandom_range(99, 0) < 75);
            PCTargetE = $urandom;
            if ($urandom_range(3, 0) == 0) PCTargetE = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            step();
        end
        reset = 1'b0; StallD = 1'b0; PCSrcE = 1'b0; rdy_in = 1'b1;
        for (int i = 0; i < 10; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
